// File: rtl/alu_pkg.sv
// Shared types and single-cycle result helpers for the alu_muldiv block.
// Helpers work on 64-bit extended operands so one definition serves every WIDTH.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'd0,
        OP_OR    = 4'd1,
        OP_XOR   = 4'd2,
        OP_NOR   = 4'd3,
        OP_ADD   = 4'd4,
        OP_SUB   = 4'd5,
        OP_SLT   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_SLL   = 4'd8,
        OP_SRL   = 4'd9,
        OP_SRA   = 4'd10,
        OP_MULT  = 4'd11,
        OP_MULTU = 4'd12,
        OP_DIV   = 4'd13,
        OP_DIVU  = 4'd14
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_muldiv(alu_op_t op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    endfunction

    // as/bs are sign-extended, au/bu zero-extended; callers keep the low WIDTH bits.
    function automatic logic [63:0] alu_single(alu_op_t op,
                                               logic [63:0] as, logic [63:0] au,
                                               logic [63:0] bs, logic [63:0] bu,
                                               logic [5:0] sh);
        case (op)
            OP_AND:  return au & bu;
            OP_OR:   return au | bu;
            OP_XOR:  return au ^ bu;
            OP_NOR:  return ~(au | bu);
            OP_ADD:  return au + bu;
            OP_SUB:  return au - bu;
            OP_SLT:  return {63'b0, $signed(as) < $signed(bs)};
            OP_SLTU: return {63'b0, au < bu};
            OP_SLL:  return au << sh;
            OP_SRL:  return au >> sh;
            OP_SRA:  return 64'($signed(as) >>> sh);
            default: return 64'b0;
        endcase
    endfunction

    function automatic logic alu_overflow(alu_op_t op, logic a_msb, logic b_msb, logic r_msb);
        case (op)
            OP_ADD:  return (a_msb == b_msb) && (r_msb != a_msb);
            OP_SUB:  return (a_msb != b_msb) && (r_msb != a_msb);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned engine: shift-add multiply or restoring divide on operand
// magnitudes, one iteration per clock for WIDTH clocks after a start pulse.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy;
    logic             div_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rsh;
    logic [WIDTH:0]   diff;

    assign mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b = (is_signed && b[WIDTH-1]) ? -b : b;
    assign done  = busy && (cnt == LAST);

    // Multiply keeps {acc, multiplier} in {hi, lo}; divide keeps {remainder, quotient}.
    assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, m_q} : '0);
    assign rsh  = {hi, lo[WIDTH-1]};
    assign diff = rsh - {1'b0, m_q};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy  <= 1'b0;
            div_q <= 1'b0;
            cnt   <= '0;
            m_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            div_q <= is_div;
            hi    <= '0;
            lo    <= is_div ? mag_a : mag_b;
            m_q   <= is_div ? mag_b : mag_a;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
            if (div_q) begin
                // A clear borrow bit means the divisor fits: keep the difference.
                if (!diff[WIDTH]) begin
                    hi <= diff[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi <= rsh[WIDTH-1:0];
                    lo <= {lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi <= sum[WIDTH:1];
                lo <= {sum[0], lo[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// ALU with single-cycle logic/arith/shift ops and an iterative multiply/divide,
// behind a valid/ready request and result handshake.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic               accept;
    alu_op_t            op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   single_r;
    logic               single_ovf;
    logic               iter_done;
    logic [WIDTH-1:0]   iter_hi, iter_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fix_lo, fix_hi;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state_q == DONE);
    assign zero      = (result_lo == '0);

    assign single_r = WIDTH'(alu_single(op, 64'($signed(a)), 64'(a),
                                        64'($signed(b)), 64'(b), 6'(b[SHW-1:0])));
    assign single_ovf = alu_overflow(op, a[WIDTH-1], b[WIDTH-1], single_r[WIDTH-1]);

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (accept && is_muldiv(op)),
        .abort     (flush),
        .is_div    (op inside {OP_DIV, OP_DIVU}),
        .is_signed (op inside {OP_MULT, OP_DIV}),
        .a         (a),
        .b         (b),
        .done      (iter_done),
        .hi        (iter_hi),
        .lo        (iter_lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = is_muldiv(op) ? BUSY : DONE;
            BUSY:    if (iter_done) state_d = FIX;
            FIX:     state_d = DONE;
            DONE: begin
                if (out_ready)
                    state_d = accept ? (is_muldiv(op) ? BUSY : DONE) : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush)
            state_d = IDLE;
    end

    // Sign correction of the unsigned engine result, applied during FIX.
    always_comb begin
        prod   = {iter_hi, iter_lo};
        quo    = iter_lo;
        rem    = iter_hi;
        fix_lo = '0;
        fix_hi = '0;
        if (op_q inside {OP_MULT, OP_MULTU}) begin
            if ((op_q == OP_MULT) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]))
                prod = -prod;
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else if (b_q == '0) begin
            fix_lo = '1;
            fix_hi = a_q;
        end else begin
            if (op_q == OP_DIV) begin
                if (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                    quo = -quo;
                if (a_q[WIDTH-1])
                    rem = -rem;
            end
            fix_lo = quo;
            fix_hi = rem;
        end
    end

    // Result registers change only on acceptance or in FIX, so DONE holds them stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= OP_AND;
            a_q       <= '0;
            b_q       <= '0;
            result_lo <= '0;
            result_hi <= '0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
                if (!is_muldiv(op)) begin
                    result_lo <= single_r;
                    result_hi <= '0;
                    overflow  <= single_ovf;
                end
            end
            if (state_q == FIX) begin
                result_lo <= fix_lo;
                result_hi <= fix_hi;
                overflow  <= 1'b0;
            end
        end
    end

endmodule
